// File: rtl/demo_sequencer_if.sv
// Control and scene-select bundle between the demo sequencer and its wrapper.
// The master side is the sequencer; the slave side is the wrapper.
interface demo_sequencer_if;
    logic       ena;
    logic       vsync_in;
    logic       btn_next;
    logic       btn_mode;
    logic [1:0] vga_state;
    logic [1:0] audio_select;
    logic [2:0] scene_idx;
    logic       auto_mode;
    logic       frame_tick;

    modport master (
        input  ena,
        input  vsync_in,
        input  btn_next,
        input  btn_mode,
        output vga_state,
        output audio_select,
        output scene_idx,
        output auto_mode,
        output frame_tick
    );

    modport slave (
        output ena,
        output vsync_in,
        output btn_next,
        output btn_mode,
        input  vga_state,
        input  audio_select,
        input  scene_idx,
        input  auto_mode,
        input  frame_tick
    );
endinterface

// File: rtl/demo_sequencer.sv
// Demo scene controller: frame counting from vsync, debounced buttons,
// auto/manual scene stepping applied only at frame boundaries.
module demo_sequencer #(
    parameter int FRAMES_PER_SCENE = 120,
    parameter int NUM_SCENES       = 8,
    parameter int DB_CYCLES        = 250000,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    demo_sequencer_if.master  bus
);
    localparam int FW = 12;
    localparam int DW = 20;
    localparam logic [FW-1:0] LAST_FRAME =
        FW'(FRAMES_PER_SCENE - 1);
    localparam logic [2:0] LAST_SCENE =
        3'(NUM_SCENES - 1);
    localparam logic [DW-1:0] DB_LAST =
        DW'(DB_CYCLES - 1);

    logic v_raw;
    logic v_s1;
    logic v_s2;
    logic v_prev;
    logic tick;

    logic [1:0]         b_raw;
    logic [1:0]         b_s1;
    logic [1:0]         b_s2;
    logic [1:0]         b_db;
    logic [1:0]         press;
    logic [1:0][DW-1:0] b_cnt;

    logic [FW-1:0] frame_cnt;
    logic          pending;
    logic          auto_q;
    logic [2:0]    scene_q;
    logic [1:0]    vga_q;
    logic [1:0]    audio_q;
    logic          adv;
    logic [2:0]    scene_nx;

    // Normalise polarity so the synchronizer always idles at 0.
    assign v_raw = (VSYNC_ACTIVE_LOW != 0) ?
                   ~bus.vsync_in : bus.vsync_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1   <= 1'b0;
            v_s2   <= 1'b0;
            v_prev <= 1'b0;
            tick   <= 1'b0;
        end else begin
            v_s1   <= v_raw;
            v_s2   <= v_s1;
            v_prev <= v_s2;
            tick   <= v_s2 & ~v_prev;
        end
    end

    assign b_raw = {bus.btn_mode, bus.btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            b_s1 <= b_raw;
            b_s2 <= b_s1;
        end
    end

    // Bit 0 is btn_next, bit 1 is btn_mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_db  <= '0;
            press <= '0;
            b_cnt <= '0;
        end else begin
            press <= '0;
            if (bus.ena) begin
                for (int i = 0; i < 2; i++) begin
                    if (b_s2[i] != b_db[i]) begin
                        if (b_cnt[i] == DB_LAST) begin
                            b_db[i]  <= b_s2[i];
                            b_cnt[i] <= '0;
                            press[i] <= b_s2[i];
                        end else begin
                            b_cnt[i] <= b_cnt[i] + DW'(1);
                        end
                    end else begin
                        b_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign adv = pending |
                 (auto_q & (frame_cnt == LAST_FRAME));
    assign scene_nx = (scene_q == LAST_SCENE) ?
                      3'd0 : scene_q + 3'd1;

    // A press in the same cycle as a tick lands after that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            pending   <= 1'b0;
            auto_q    <= 1'b1;
            scene_q   <= 3'd0;
            vga_q     <= 2'd0;
            audio_q   <= 2'd0;
        end else if (bus.ena) begin
            if (tick) begin
                if (adv) begin
                    scene_q   <= scene_nx;
                    vga_q     <= scene_nx[1:0];
                    audio_q   <= scene_nx[2:1];
                    frame_cnt <= '0;
                    pending   <= 1'b0;
                end else if (auto_q) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end else begin
                    frame_cnt <= '0;
                end
            end
            if (press[0]) begin
                pending <= 1'b1;
            end
            if (press[1]) begin
                auto_q <= ~auto_q;
                if (!auto_q) begin
                    frame_cnt <= '0;
                end
            end
        end
    end

    assign bus.frame_tick   = tick;
    assign bus.scene_idx    = scene_q;
    assign bus.vga_state    = vga_q;
    assign bus.audio_select = audio_q;
    assign bus.auto_mode    = auto_q;
endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer: scene stepping, debounce,
// same-cycle events, ena freeze and mid-frame reset.
module tb_demo_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    demo_sequencer_if bus();

    demo_sequencer #(
        .FRAMES_PER_SCENE(3),
        .NUM_SCENES(5),
        .DB_CYCLES(4),
        .VSYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ticks = 0;
    int t0 = 0;

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) ticks++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_scene(input string tag, input int s);
        chk(tag, 32'(bus.scene_idx), s);
        chk({tag, "_vga"}, 32'(bus.vga_state), s % 4);
        chk({tag, "_aud"}, 32'(bus.audio_select), (s >> 1) & 3);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        bus.vsync_in = 1'b0;
        cyc(4);
        bus.vsync_in = 1'b1;
        cyc(46);
    endtask

    task automatic press_next();
        bus.btn_next = 1'b1;
        cyc(6);
        bus.btn_next = 1'b0;
        cyc(8);
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        cyc(6);
        bus.btn_mode = 1'b0;
        cyc(8);
    endtask

    initial begin
        bus.ena      = 1'b1;
        bus.vsync_in = 1'b1;
        bus.btn_next = 1'b0;
        bus.btn_mode = 1'b0;
        #1 rst_n = 1'b0;
        cyc(3);
        chk_scene("rst_scene", 0);
        chk("rst_auto", 32'(bus.auto_mode), 1);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        rst_n = 1'b1;
        cyc(5);

        // first frame: tick on 3rd edge, one cycle wide
        bus.vsync_in = 1'b0;
        cyc(1);
        chk("tick_e1", 32'(bus.frame_tick), 0);
        cyc(1);
        chk("tick_e2", 32'(bus.frame_tick), 0);
        cyc(1);
        chk("tick_e3", 32'(bus.frame_tick), 1);
        cyc(1);
        chk("tick_e4", 32'(bus.frame_tick), 0);
        bus.vsync_in = 1'b1;
        cyc(46);
        chk_scene("auto_f1", 0);

        for (int f = 2; f <= 16; f++) begin
            frame();
            if (f % 3 == 0)
                chk_scene($sformatf("auto_f%0d", f), (f / 3) % 5);
        end
        chk_scene("auto_f16", 0);
        chk("tick_count", ticks, 16);

        // manual mode
        press_mode();
        chk("manual_on", 32'(bus.auto_mode), 0);
        chk_scene("manual_hold0", 0);
        for (int f = 0; f < 10; f++) frame();
        chk_scene("manual_10f", 0);
        press_next();
        chk_scene("pend_no_tick", 0);
        frame();
        chk_scene("next_adv", 1);
        frame();
        chk_scene("next_once", 1);
        press_next();
        press_next();
        press_next();
        frame();
        chk_scene("multi_press", 2);
        frame();
        chk_scene("multi_once", 2);

        // debounce
        bus.btn_next = 1'b1;
        cyc(3);
        bus.btn_next = 1'b0;
        cyc(10);
        frame();
        chk_scene("glitch_rej", 2);
        bus.btn_next = 1'b1;
        cyc(1);
        bus.btn_next = 1'b0;
        cyc(1);
        bus.btn_next = 1'b1;
        cyc(7);
        bus.btn_next = 1'b0;
        cyc(8);
        frame();
        chk_scene("bounce_one", 3);
        frame();
        chk_scene("bounce_once", 3);

        // back to auto: pending meets rollover
        press_mode();
        chk("auto_on", 32'(bus.auto_mode), 1);
        chk_scene("toggle_keep", 3);
        frame();
        frame();
        chk_scene("auto_cnt2", 3);
        press_next();
        frame();
        chk_scene("pend_roll", 4);
        frame();
        frame();
        chk_scene("roll_cnt0", 4);
        frame();
        chk_scene("roll_next", 0);

        // press pulse coincides with frame_tick
        bus.btn_next = 1'b1;
        cyc(3);
        bus.vsync_in = 1'b0;
        cyc(3);
        chk("same_tick", 32'(bus.frame_tick), 1);
        cyc(1);
        bus.vsync_in = 1'b1;
        bus.btn_next = 1'b0;
        cyc(46);
        chk_scene("same_not_now", 0);
        frame();
        chk_scene("same_next", 1);

        // ena freeze
        bus.ena = 1'b0;
        t0 = ticks;
        for (int f = 0; f < 8; f++) begin
            frame();
            if (f == 1) press_next();
            if (f == 4) press_mode();
        end
        chk_scene("ena_hold", 1);
        chk("ena_auto", 32'(bus.auto_mode), 1);
        chk("ena_ticks", ticks - t0, 8);
        bus.ena = 1'b1;
        cyc(2);
        frame();
        frame();
        chk_scene("ena_cnt_kept", 1);
        frame();
        chk_scene("ena_resume", 2);
        for (int f = 0; f < 6; f++) frame();
        chk_scene("pre_rst", 4);
        press_mode();
        chk("pre_rst_manual", 32'(bus.auto_mode), 0);

        // asynchronous reset mid-frame
        bus.vsync_in = 1'b0;
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk_scene("arst", 0);
        chk("arst_auto", 32'(bus.auto_mode), 1);
        chk("arst_tick", 32'(bus.frame_tick), 0);
        t0 = ticks;
        cyc(2);
        bus.vsync_in = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_noTick", ticks - t0, 0);
        frame();
        frame();
        chk_scene("post_rst_2f", 0);
        chk("post_rst_ticks", ticks - t0, 2);
        frame();
        chk_scene("post_rst_3f", 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
